pacman_motion_ctrl: RTL and testbench
=====================================

PACMAN_MOTION_CTRL -- requirements
Module: pacman_motion_ctrl

Interface
REQ-001 Parameter STEP, default 10'd2, pixels moved per game tick; SHALL evenly divide 60.
REQ-002 Parameter START_X, default 10'd210, reset x pixel; tile-aligned.
REQ-003 Parameter START_Y, default 10'd94, reset y pixel; tile-aligned.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 tick  in  1  game-tick pulse, one clk wide.
REQ-007 l, r, u, d  in  1 each  player direction buttons, level.
REQ-008 leg_l, leg_r, leg_u, leg_d  in  1 each  legal-move bits from the legal-move lookup, combinational from xpos/ypos.
REQ-009 xpos  out  10  sprite x pixel, top-left origin; also drives the lookup x input.
REQ-010 ypos  out  10  sprite y pixel; also drives the lookup y input.
REQ-011 dir  out  2  current heading: 0=L, 1=R, 2=U, 3=D (same order as legal bits).
REQ-012 moving  out  1  sprite advances on the next step.
REQ-013 busy  out  1  high while the FSM is not in IDLE.
REQ-014 tick_miss  out  1  sticky flag: a tick was dropped.

Function
REQ-015 Grid: origin (150,34), tile 60 px, 8x8 tiles; aligned means (xpos-150) mod 60 == 0 and (ypos-34) mod 60 == 0.
REQ-016 Offsets: SHALL keep registers x_off, y_off (0..59) tracking the offsets above; updated with wrap 59->0 and 0->59; no divider.
REQ-017 Pending turn: on any cycle with a button high, SHALL latch pend_dir with priority l>r>u>d and set pend_v; a newer press overwrites.
REQ-018 FSM states: IDLE, QUERY, DECIDE, STEP; SHALL return to IDLE after STEP.
REQ-019 IDLE->QUERY when tick=1; otherwise stay.
REQ-020 QUERY->DECIDE unconditionally; at this edge SHALL register the four leg_* inputs into leg_q.
REQ-021 DECIDE->STEP. If aligned, the following SHALL apply in order:
- if pend_v and leg_q[pend_dir]: dir<=pend_dir, moving<=1, pend_v<=0;
- else if leg_q[dir]: moving<=1;
- else: moving<=0.
REQ-022 DECIDE when not aligned:
- if pend_v and pend_dir is the reverse of dir: dir<=pend_dir, pend_v<=0, moving<=1;
- other pending turns stay latched.
REQ-023 STEP: if moving, add or subtract STEP on the dir axis (L: x-, R: x+, U: y-, D: y+) and update the matching offset; else hold.
REQ-024 Clamp: a step giving x<150, x>570, y<34 or y>454 SHALL be suppressed and moving<=0.
REQ-025 Latency: position changes on the 3rd rising edge after the edge that samples tick.
REQ-026 Tick seen while busy=1 SHALL be dropped and SHALL set tick_miss; tick_miss clears only on reset.
REQ-027 Button input during busy SHALL still update pend_dir/pend_v; DECIDE uses the value registered before its edge.
REQ-028 busy SHALL be 1 exactly in QUERY, DECIDE and STEP.

Reset
REQ-029 rst=1 asynchronously forces the following, regardless of FSM state, including mid-sequence:
- FSM=IDLE, xpos=START_X, ypos=START_Y;
- x_off=0, y_off=0;
- dir=1 (R), moving=0;
- pend_v=0, pend_dir=0;
- leg_q=0, tick_miss=0, busy=0.
REQ-030 After rst deasserts, the first tick SHALL be processed normally.

Verification
REQ-031 Reset at (210,94); hold r, legal=0100 (R only); one tick -> at 3rd edge xpos=212, dir=1, moving=1, busy high for 3 cycles.
REQ-032 Mid-tile turn: x_off=20, pend up, legal=1100 -> dir unchanged, x advances by 2 per tick; on reaching x_off=0 with legal=0010 -> dir=2 and y decreases by 2.
REQ-033 Reversal: moving R at x_off=10, press l -> DECIDE sets dir=0; next STEP xpos decreases by 2 with no alignment wait.
REQ-034 Wall: aligned, dir=R, no pending, legal=0000 -> moving=0, xpos unchanged over 5 ticks.
REQ-035 Tick overlap: second tick 1 cycle after the first -> tick_miss=1 and exactly one step taken; rst asserted during STEP -> immediate return to (210,94), tick_miss=0.

Source files
------------

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man sprite motion controller: tick-driven IDLE/QUERY/DECIDE/STEP sequence that
// samples the legal-move lookup, applies pending turns and advances the sprite on an 8x8 grid.
module pacman_motion_ctrl #(
    parameter logic [9:0] STEP    = 10'd2,
    parameter logic [9:0] START_X = 10'd210,
    parameter logic [9:0] START_Y = 10'd94
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       l,
    input  logic       r,
    input  logic       u,
    input  logic       d,
    input  logic       leg_l,
    input  logic       leg_r,
    input  logic       leg_u,
    input  logic       leg_d,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [1:0] dir,
    output logic       moving,
    output logic       busy,
    output logic       tick_miss
);

    localparam logic [9:0] XMin = 10'd150;
    localparam logic [9:0] XMax = 10'd570;
    localparam logic [9:0] YMin = 10'd34;
    localparam logic [9:0] YMax = 10'd454;
    localparam logic [5:0] Tile = 6'd60;
    localparam logic [5:0] StepOff = STEP[5:0];

    localparam logic [1:0] DirL = 2'd0;
    localparam logic [1:0] DirR = 2'd1;
    localparam logic [1:0] DirU = 2'd2;
    localparam logic [1:0] DirD = 2'd3;

    typedef enum logic [1:0] {StIdle, StQuery, StDecide, StStep} state_e;

    state_e     state_q, state_d;
    logic [9:0] xpos_q, xpos_d;
    logic [9:0] ypos_q, ypos_d;
    logic [5:0] x_off_q, x_off_d;
    logic [5:0] y_off_q, y_off_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;
    logic       pend_v_q, pend_v_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic [3:0] leg_q, leg_nxt;
    logic       tick_miss_q, tick_miss_d;
    logic       busy_q, busy_d;

    logic       aligned;
    logic       btn_any;
    logic [1:0] btn_dir;
    logic       step_ok;
    logic [9:0] step_x, step_y;
    logic [5:0] step_xo, step_yo;

    // Offset arithmetic modulo one tile, relying on STEP dividing the tile size.
    function automatic logic [5:0] off_inc(input logic [5:0] off);
        logic [6:0] sum;
        sum = {1'b0, off} + {1'b0, StepOff};
        if (sum >= {1'b0, Tile}) begin
            sum = sum - {1'b0, Tile};
        end
        return sum[5:0];
    endfunction

    function automatic logic [5:0] off_dec(input logic [5:0] off);
        logic [5:0] res;
        if (off < StepOff) begin
            res = off + (Tile - StepOff);
        end else begin
            res = off - StepOff;
        end
        return res;
    endfunction

    assign aligned = (x_off_q == 6'd0) && (y_off_q == 6'd0);
    assign btn_any = l | r | u | d;

    always_comb begin
        if (l) begin
            btn_dir = DirL;
        end else if (r) begin
            btn_dir = DirR;
        end else if (u) begin
            btn_dir = DirU;
        end else begin
            btn_dir = DirD;
        end
    end

    // Candidate position for the STEP state; step_ok drops when the move would leave the maze.
    always_comb begin
        step_x  = xpos_q;
        step_y  = ypos_q;
        step_xo = x_off_q;
        step_yo = y_off_q;
        step_ok = 1'b1;
        unique case (dir_q)
            DirL: begin
                if (xpos_q < XMin + STEP) begin
                    step_ok = 1'b0;
                end else begin
                    step_x  = xpos_q - STEP;
                    step_xo = off_dec(x_off_q);
                end
            end
            DirR: begin
                if (xpos_q > XMax - STEP) begin
                    step_ok = 1'b0;
                end else begin
                    step_x  = xpos_q + STEP;
                    step_xo = off_inc(x_off_q);
                end
            end
            DirU: begin
                if (ypos_q < YMin + STEP) begin
                    step_ok = 1'b0;
                end else begin
                    step_y  = ypos_q - STEP;
                    step_yo = off_dec(y_off_q);
                end
            end
            DirD: begin
                if (ypos_q > YMax - STEP) begin
                    step_ok = 1'b0;
                end else begin
                    step_y  = ypos_q + STEP;
                    step_yo = off_inc(y_off_q);
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        x_off_d     = x_off_q;
        y_off_d     = y_off_q;
        dir_d       = dir_q;
        moving_d    = moving_q;
        pend_v_d    = pend_v_q;
        pend_dir_d  = pend_dir_q;
        leg_nxt     = leg_q;
        tick_miss_d = tick_miss_q;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StQuery;
                end
            end
            StQuery: begin
                leg_nxt = {leg_d, leg_u, leg_r, leg_l};
                state_d = StDecide;
            end
            StDecide: begin
                state_d = StStep;
                if (aligned) begin
                    if (pend_v_q && leg_q[pend_dir_q]) begin
                        dir_d    = pend_dir_q;
                        moving_d = 1'b1;
                        pend_v_d = 1'b0;
                    end else begin
                        moving_d = leg_q[dir_q];
                    end
                end else if (pend_v_q && (pend_dir_q == (dir_q ^ 2'b01))) begin
                    // Reversal is always legal mid-tile: we just came from there.
                    dir_d    = pend_dir_q;
                    pend_v_d = 1'b0;
                    moving_d = 1'b1;
                end
            end
            StStep: begin
                state_d = StIdle;
                if (moving_q) begin
                    if (step_ok) begin
                        xpos_d  = step_x;
                        ypos_d  = step_y;
                        x_off_d = step_xo;
                        y_off_d = step_yo;
                    end else begin
                        moving_d = 1'b0;
                    end
                end
            end
        endcase

        if (tick && (state_q != StIdle)) begin
            tick_miss_d = 1'b1;
        end

        // A press on the DECIDE edge wins over the consume-clear.
        if (btn_any) begin
            pend_v_d   = 1'b1;
            pend_dir_d = btn_dir;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            xpos_q      <= START_X;
            ypos_q      <= START_Y;
            x_off_q     <= 6'd0;
            y_off_q     <= 6'd0;
            dir_q       <= DirR;
            moving_q    <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_dir_q  <= 2'd0;
            leg_q       <= 4'd0;
            tick_miss_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            x_off_q     <= x_off_d;
            y_off_q     <= y_off_d;
            dir_q       <= dir_d;
            moving_q    <= moving_d;
            pend_v_q    <= pend_v_d;
            pend_dir_q  <= pend_dir_d;
            leg_q       <= leg_nxt;
            tick_miss_q <= tick_miss_d;
            busy_q      <= busy_d;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign busy      = busy_q;
    assign tick_miss = tick_miss_q;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Self-checking bench for pacman_motion_ctrl: directed scenarios plus randomized ticks
// against a per-tick behavioural model of the sprite.
module tb_pacman_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       l, r, u, d;
    logic       leg_l, leg_r, leg_u, leg_d;
    logic [9:0] xpos, ypos;
    logic [1:0] dir;
    logic       moving, busy, tick_miss;

    int checks = 0;
    int errors = 0;

    int m_x, m_y, m_dir, m_mv, m_pv, m_pd, m_miss;

    // Lookup table stand-in; vectors are {L,R,U,D} left to right.
    logic [3:0] legmap [0:255];
    logic       force_en;
    logic [3:0] force_val;
    logic [3:0] leg_vec;

    pacman_motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .l         (l),
        .r         (r),
        .u         (u),
        .d         (d),
        .leg_l     (leg_l),
        .leg_r     (leg_r),
        .leg_u     (leg_u),
        .leg_d     (leg_d),
        .xpos      (xpos),
        .ypos      (ypos),
        .dir       (dir),
        .moving    (moving),
        .busy      (busy),
        .tick_miss (tick_miss)
    );

    always #5 clk = ~clk;

    always_comb begin
        leg_vec = force_en ? force_val : legmap[xpos[7:0] ^ {ypos[4:0], 3'b000}];
    end
    assign {leg_l, leg_r, leg_u, leg_d} = leg_vec;

    function automatic logic [3:0] lookup(input int x, input int y);
        return legmap[(x & 255) ^ ((y * 8) & 255)];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 210; m_y = 94; m_dir = 1; m_mv = 0; m_pv = 0; m_pd = 0; m_miss = 0;
    endtask

    task automatic model_press(input logic [3:0] b);
        if (b != 4'b0) begin
            m_pv = 1;
            m_pd = b[3] ? 0 : (b[2] ? 1 : (b[1] ? 2 : 3));
        end
    endtask

    // One whole tick: decide on the tile-grid rules, then try one STEP move.
    task automatic model_tick(input logic [3:0] legv, input int bk, input logic [3:0] bv,
                              input int extra);
        int opp[4] = '{1, 0, 3, 2};
        int dx[4]  = '{-1, 1, 0, 0};
        int dy[4]  = '{0, 0, -1, 1};
        bit aligned;
        int nx, ny;
        if (bk == 1) model_press(bv);
        aligned = ((m_x - 150) % 60 == 0) && ((m_y - 34) % 60 == 0);
        if (aligned) begin
            if (m_pv != 0 && legv[3 - m_pd]) begin
                m_dir = m_pd; m_mv = 1; m_pv = 0;
            end else begin
                m_mv = legv[3 - m_dir] ? 1 : 0;
            end
        end else if (m_pv != 0 && m_pd == opp[m_dir]) begin
            m_dir = m_pd; m_pv = 0; m_mv = 1;
        end
        if (bk >= 2) model_press(bv);
        if (m_mv != 0) begin
            nx = m_x + 2 * dx[m_dir];
            ny = m_y + 2 * dy[m_dir];
            if (nx < 150 || nx > 570 || ny < 34 || ny > 454) m_mv = 0;
            else begin
                m_x = nx; m_y = ny;
            end
        end
        if (extra != 0) m_miss = 1;
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge clk);
        {l, r, u, d} = b;
        @(negedge clk);
        {l, r, u, d} = 4'b0;
        model_press(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // extra: cycle (1..3) after the tick edge carrying a second tick; bk/bv: button press cycle.
    task automatic do_tick(input int extra, input int bk, input logic [3:0] bv);
        logic [3:0] legv;
        legv = force_en ? force_val : lookup(m_x, m_y);
        model_tick(legv, bk, bv, extra);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick = (extra == k);
            {l, r, u, d} = (bk == k) ? bv : 4'b0;
            check("busy_seq", busy, 1);
            @(negedge clk);
        end
        tick = 1'b0;
        {l, r, u, d} = 4'b0;
        check("busy_idle", busy, 0);
        check("xpos", xpos, m_x);
        check("ypos", ypos, m_y);
        check("dir", dir, m_dir);
        check("moving", moving, m_mv);
        check("tick_miss", tick_miss, m_miss);
    endtask

    initial begin
        int bk, ex;
        logic [3:0] bv;
        rst = 1'b1; tick = 1'b0; {l, r, u, d} = 4'b0;
        force_en = 1'b1; force_val = 4'b0100;
        for (int i = 0; i < 256; i++) legmap[i] = 4'($urandom_range(0, 15));
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_x", xpos, 210);
        check("rst_y", ypos, 94);
        check("rst_dir", dir, 1);
        check("rst_moving", moving, 0);
        check("rst_busy", busy, 0);
        check("rst_miss", tick_miss, 0);
        rst = 1'b0;

        // First move right from the start tile.
        press(4'b0100);
        do_tick(0, 0, 4'b0);
        check("r31_x", xpos, 212);
        check("r31_dir", dir, 1);

        // Mid-tile pending up is held until the next aligned tile.
        repeat (9) do_tick(0, 0, 4'b0);
        check("r32_x_off20", xpos, 230);
        force_val = 4'b1100;
        press(4'b0010);
        repeat (20) do_tick(0, 0, 4'b0);
        check("r32_x_aligned", xpos, 270);
        check("r32_dir_held", dir, 1);
        force_val = 4'b0010;
        do_tick(0, 0, 4'b0);
        check("r32_turn_dir", dir, 2);
        check("r32_turn_y", ypos, 92);

        // Reversal mid-tile.
        do_reset();
        force_val = 4'b0100;
        press(4'b0100);
        repeat (5) do_tick(0, 0, 4'b0);
        press(4'b1000);
        do_tick(0, 0, 4'b0);
        check("r33_dir", dir, 0);
        check("r33_x", xpos, 218);

        // Wall ahead, then a press during DECIDE is latched but not used until the next tick.
        do_reset();
        force_val = 4'b0000;
        repeat (5) do_tick(0, 0, 4'b0);
        check("r34_x", xpos, 210);
        check("r34_moving", moving, 0);
        force_val = 4'b0010;
        do_tick(0, 2, 4'b0010);
        check("r27_late_dir", dir, 1);
        do_tick(0, 0, 4'b0);
        check("r27_used_dir", dir, 2);
        do_tick(0, 1, 4'b1000);
        check("r27_nonrev_y", ypos, 90);

        // Left edge of the maze.
        do_reset();
        force_val = 4'b1000;
        press(4'b1000);
        repeat (31) do_tick(0, 0, 4'b0);
        check("clamp_x", xpos, 150);
        check("clamp_moving", moving, 0);

        // Overlapping tick, then asynchronous reset during STEP.
        do_reset();
        force_val = 4'b0100;
        press(4'b0100);
        do_tick(1, 0, 4'b0);
        check("r35_x", xpos, 212);
        check("r35_miss", tick_miss, 1);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("r35_async_x", xpos, 210);
        check("r35_async_y", ypos, 94);
        check("r35_async_miss", tick_miss, 0);
        check("r35_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_tick(0, 0, 4'b0);
        check("r30_x", xpos, 212);

        // Randomized play over a random legal-move map.
        force_en = 1'b0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 59) do_reset();
            if ($urandom_range(0, 2) == 0) press(4'($urandom_range(1, 15)));
            bk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            bv = 4'($urandom_range(1, 15));
            ex = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_tick(ex, bk, bv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
